instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 MemReq  output  1  instruction-memory read request.
REQ-005 MemAddr  output  16  word address of the request; equals PC.
REQ-006 MemAck  input  1  memory handshake; MemData valid in the same cycle.
REQ-007 MemData  input  16  instruction word from memory.
REQ-008 IR  output  16  latched instruction for the decoder.
REQ-009 IRPC  output  16  address the IR word was fetched from.
REQ-010 IRValid  output  1  IR/IRPC hold an unconsumed instruction.
REQ-011 DecReady  input  1  decoder consumes IR in a cycle where IRValid=1.
REQ-012 Halt  input  1  decoder halt request, sampled only on consume.
REQ-013 Redirect  input  1  branch/jump taken; overrides sequential fetch.
REQ-014 RedirectPC  input  16  target address for Redirect.
REQ-015 PC  output  16  next fetch address.

Function
REQ-016 The FSM SHALL have exactly three states: REQ, HOLD and HALTED.
REQ-017 MemReq SHALL be 1 if and only if state=REQ and Reset=0; MemAddr SHALL equal PC combinationally.
REQ-018 In REQ with MemAck=1 and Redirect=0, the block SHALL set IR<=MemData, IRPC<=PC, IRValid<=1 and PC<=PC+1, and go to HOLD.
REQ-019 PC+1 SHALL be 16-bit modulo: FFFF+1=0000, with no carry out.
REQ-020 In REQ with MemAck=0, the block SHALL stay in REQ and hold MemReq high, with no timeout.
REQ-021 Latency SHALL be one cycle: IRValid rises on the edge that ends the MemAck cycle.
REQ-022 In HOLD, IR, IRPC, IRValid and PC SHALL hold while DecReady=0, and MemReq SHALL be 0.
REQ-023 In HOLD with DecReady=1 and Halt=0, the block SHALL set IRValid<=0 and go to REQ.
REQ-024 In HOLD with DecReady=1 and Halt=1, the block SHALL set IRValid<=0 and go to HALTED.
REQ-025 In HALTED, MemReq SHALL be 0 and MemAck SHALL be ignored; the state SHALL be left only by Redirect or Reset.
REQ-026 Redirect=1 in any state SHALL cause PC<=RedirectPC, IRValid<=0 and next state REQ.
REQ-027 Redirect SHALL take priority over a same-cycle MemAck, which discards MemData, and over DecReady/Halt.
REQ-028 Priority order SHALL be: Reset > Redirect > Halt/DecReady > MemAck.
REQ-029 Halt SHALL be ignored when state is not HOLD or DecReady=0.

Reset
REQ-030 On Reset=1 at a clock edge, the block SHALL set PC<=RESET_PC, IR<=0, IRPC<=0, IRValid<=0 and state<=REQ.
REQ-031 Reset SHALL abort any outstanding request; a MemAck in the reset cycle SHALL be ignored.
REQ-032 The first MemReq SHALL assert in the first cycle with Reset=0, addressing RESET_PC.

Structure
REQ-033 State encoding, RESET_PC default and the 16-bit word width SHALL live in the shared processor package.
REQ-034 The PC+1 adder SHALL be a separate sub-module, pc_incr: 16-bit in, 16-bit out, wrap, no flags.
REQ-035 The block SHALL contain no combinational path from MemData to IR outputs; IR SHALL be registered only.

Verification
REQ-036 Reset 1 cycle, then MemAck=1 and MemData=16'h1234 in the first cycle -> that cycle shows MemAddr=0000; next cycle shows IR=1234, IRPC=0000, IRValid=1, PC=0001.
REQ-037 DecReady=0 for 3 cycles in HOLD -> IR and PC unchanged and MemReq=0 throughout; DecReady=1 -> next cycle MemReq=1 and MemAddr=0001.
REQ-038 In REQ with MemAck=0 and Redirect=1, RedirectPC=0040 -> next cycle MemAddr=0040; repeated with MemAck=1 in the same cycle -> IRValid stays 0.
REQ-039 Redirect to FFFF, then MemAck with MemData=ABCD -> IRPC=FFFF and PC=0000.
REQ-040 In HOLD, DecReady=1 and Halt=1 -> HALTED; MemReq stays 0 for 10 cycles despite MemAck=1; Redirect with RedirectPC=0010 -> REQ with MemAddr=0010.
REQ-041 Reset=1 mid-REQ (PC=0005) with MemAck=1 -> next cycle PC=RESET_PC, IRValid=0, IR=0.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared processor definitions for the instruction fetch unit: word width,
// reset PC default and fetch FSM state encoding.
package instr_fetch_pkg;

    localparam int unsigned WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

endpackage : instr_fetch_pkg

// File: rtl/instr_fetch_if.sv
// Instruction-memory read bus between the fetch unit (master) and memory (slave).
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic  MemReq;
    word_t MemAddr;
    logic  MemAck;
    word_t MemData;

    modport master (
        output MemReq,
        output MemAddr,
        input  MemAck,
        input  MemData
    );

    modport slave (
        input  MemReq,
        input  MemAddr,
        output MemAck,
        output MemData
    );

endinterface : instr_fetch_if

// File: rtl/instr_fetch_pc_incr.sv
// Sequential PC adder: 16-bit modulo increment, no carry or flags.
module pc_incr
    import instr_fetch_pkg::*;
(
    input  word_t pc_in,
    output word_t pc_out
);

    assign pc_out = pc_in + word_t'(1);

endmodule : pc_incr

// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests one word at PC, latches it into IR for the
// decoder, and waits for consume, halt or redirect before fetching again.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 Reset,
    instr_fetch_if.master        mem,
    output word_t                IR,
    output word_t                IRPC,
    output logic                 IRValid,
    input  logic                 DecReady,
    input  logic                 Halt,
    input  logic                 Redirect,
    input  word_t                RedirectPC,
    output word_t                PC
);

    fetch_state_e state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        ir_q, ir_d;
    word_t        irpc_q, irpc_d;
    logic         ir_valid_q, ir_valid_d;
    word_t        pc_plus1;

    pc_incr u_pc_incr (
        .pc_in  (pc_q),
        .pc_out (pc_plus1)
    );

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            irpc_q     <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            irpc_q     <= irpc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    // Next-state logic: Redirect beats decoder consume/halt, which beats MemAck.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        irpc_d     = irpc_q;
        ir_valid_d = ir_valid_q;

        if (Redirect) begin
            pc_d       = RedirectPC;
            ir_valid_d = 1'b0;
            state_d    = ST_REQ;
        end else begin
            unique case (state_q)
                ST_REQ: begin
                    if (mem.MemAck) begin
                        ir_d       = mem.MemData;
                        irpc_d     = pc_q;
                        ir_valid_d = 1'b1;
                        pc_d       = pc_plus1;
                        state_d    = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (DecReady) begin
                        ir_valid_d = 1'b0;
                        state_d    = Halt ? ST_HALTED : ST_REQ;
                    end
                end
                ST_HALTED: begin
                    state_d = ST_HALTED;
                end
                default: begin
                    state_d = ST_REQ;
                end
            endcase
        end
    end

    // Reset gates the request so nothing is issued in a reset cycle.
    always_comb begin
        mem.MemReq  = (state_q == ST_REQ) && !Reset;
        mem.MemAddr = pc_q;
    end

    assign IR      = ir_q;
    assign IRPC    = irpc_q;
    assign IRValid = ir_valid_q;
    assign PC      = pc_q;

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic  CLK;
    logic  Reset;
    logic  DecReady;
    logic  Halt;
    logic  Redirect;
    word_t RedirectPC;
    word_t IR;
    word_t IRPC;
    logic  IRValid;
    word_t PC;

    int unsigned errors = 0;
    int unsigned checks = 0;

    instr_fetch_if mem_bus ();

    instr_fetch #(.RESET_PC(16'h0000)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .mem        (mem_bus.master),
        .IR         (IR),
        .IRPC       (IRPC),
        .IRValid    (IRValid),
        .DecReady   (DecReady),
        .Halt       (Halt),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .PC         (PC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        Reset           = 1'b1;
        DecReady        = 1'b0;
        Halt            = 1'b0;
        Redirect        = 1'b0;
        RedirectPC      = '0;
        mem_bus.MemAck  = 1'b0;
        mem_bus.MemData = '0;

        // Reset state
        step();
        chk("rst_memreq", 16'(mem_bus.MemReq), 16'h0);
        chk("rst_pc", PC, 16'h0000);
        chk("rst_irvalid", 16'(IRValid), 16'h0);
        chk("rst_ir", IR, 16'h0000);
        chk("rst_irpc", IRPC, 16'h0000);

        // First fetch right after reset
        Reset = 1'b0;
        mem_bus.MemAck  = 1'b1;
        mem_bus.MemData = 16'h1234;
        #1;
        chk("first_memreq", 16'(mem_bus.MemReq), 16'h1);
        chk("first_memaddr", mem_bus.MemAddr, 16'h0000);
        step();
        mem_bus.MemAck = 1'b0;
        chk("fetch1_ir", IR, 16'h1234);
        chk("fetch1_irpc", IRPC, 16'h0000);
        chk("fetch1_irvalid", 16'(IRValid), 16'h1);
        chk("fetch1_pc", PC, 16'h0001);
        chk("fetch1_memreq", 16'(mem_bus.MemReq), 16'h0);

        // HOLD with decoder stalled; Halt without DecReady is ignored
        for (int i = 0; i < 3; i++) begin
            Halt = (i == 1);
            step();
            chk("hold_ir", IR, 16'h1234);
            chk("hold_pc", PC, 16'h0001);
            chk("hold_irvalid", 16'(IRValid), 16'h1);
            chk("hold_memreq", 16'(mem_bus.MemReq), 16'h0);
        end
        Halt = 1'b0;

        // Consume -> REQ at next PC
        DecReady = 1'b1;
        step();
        DecReady = 1'b0;
        chk("consume_memreq", 16'(mem_bus.MemReq), 16'h1);
        chk("consume_memaddr", mem_bus.MemAddr, 16'h0001);
        chk("consume_irvalid", 16'(IRValid), 16'h0);

        // No ack: wait indefinitely in REQ; Halt/DecReady ignored outside HOLD
        Halt = 1'b1;
        DecReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_memreq", 16'(mem_bus.MemReq), 16'h1);
            chk("wait_memaddr", mem_bus.MemAddr, 16'h0001);
        end
        Halt = 1'b0;
        DecReady = 1'b0;

        // Redirect in REQ without ack
        Redirect   = 1'b1;
        RedirectPC = 16'h0040;
        step();
        Redirect = 1'b0;
        chk("redir_memaddr", mem_bus.MemAddr, 16'h0040);
        chk("redir_memreq", 16'(mem_bus.MemReq), 16'h1);

        // Redirect beats same-cycle MemAck: data discarded
        Redirect        = 1'b1;
        RedirectPC      = 16'h0050;
        mem_bus.MemAck  = 1'b1;
        mem_bus.MemData = 16'hDEAD;
        step();
        Redirect       = 1'b0;
        mem_bus.MemAck = 1'b0;
        chk("redir_ack_irvalid", 16'(IRValid), 16'h0);
        chk("redir_ack_ir", IR, 16'h1234);
        chk("redir_ack_memaddr", mem_bus.MemAddr, 16'h0050);

        // PC wrap at FFFF
        Redirect   = 1'b1;
        RedirectPC = 16'hFFFF;
        step();
        Redirect        = 1'b0;
        mem_bus.MemAck  = 1'b1;
        mem_bus.MemData = 16'hABCD;
        step();
        mem_bus.MemAck = 1'b0;
        chk("wrap_ir", IR, 16'hABCD);
        chk("wrap_irpc", IRPC, 16'hFFFF);
        chk("wrap_pc", PC, 16'h0000);
        chk("wrap_irvalid", 16'(IRValid), 16'h1);

        // Halt on consume -> HALTED, acks ignored
        DecReady = 1'b1;
        Halt     = 1'b1;
        step();
        DecReady = 1'b0;
        Halt     = 1'b0;
        chk("halt_irvalid", 16'(IRValid), 16'h0);
        mem_bus.MemAck  = 1'b1;
        mem_bus.MemData = 16'h9999;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("halted_memreq", 16'(mem_bus.MemReq), 16'h0);
            step();
            chk("halted_irvalid", 16'(IRValid), 16'h0);
            chk("halted_pc", PC, 16'h0000);
        end
        mem_bus.MemAck = 1'b0;
        chk("halted_ir", IR, 16'hABCD);

        // Redirect leaves HALTED
        Redirect   = 1'b1;
        RedirectPC = 16'h0010;
        step();
        Redirect = 1'b0;
        chk("unhalt_memreq", 16'(mem_bus.MemReq), 16'h1);
        chk("unhalt_memaddr", mem_bus.MemAddr, 16'h0010);

        // Redirect beats DecReady/Halt in HOLD
        mem_bus.MemAck  = 1'b1;
        mem_bus.MemData = 16'h5555;
        step();
        mem_bus.MemAck = 1'b0;
        chk("fetch2_ir", IR, 16'h5555);
        chk("fetch2_pc", PC, 16'h0011);
        Redirect   = 1'b1;
        RedirectPC = 16'h0020;
        DecReady   = 1'b1;
        Halt       = 1'b1;
        step();
        Redirect = 1'b0;
        DecReady = 1'b0;
        Halt     = 1'b0;
        chk("redir_hold_memreq", 16'(mem_bus.MemReq), 16'h1);
        chk("redir_hold_memaddr", mem_bus.MemAddr, 16'h0020);
        chk("redir_hold_irvalid", 16'(IRValid), 16'h0);

        // Reset mid-REQ at PC=0005 with ack in the reset cycle
        Redirect   = 1'b1;
        RedirectPC = 16'h0005;
        step();
        Redirect = 1'b0;
        chk("pre_rst_pc", PC, 16'h0005);
        Reset           = 1'b1;
        mem_bus.MemAck  = 1'b1;
        mem_bus.MemData = 16'h7777;
        #1;
        chk("rst_cycle_memreq", 16'(mem_bus.MemReq), 16'h0);
        step();
        Reset          = 1'b0;
        mem_bus.MemAck = 1'b0;
        chk("midrst_pc", PC, 16'h0000);
        chk("midrst_irvalid", 16'(IRValid), 16'h0);
        chk("midrst_ir", IR, 16'h0000);
        chk("midrst_irpc", IRPC, 16'h0000);
        #1;
        chk("post_rst_memreq", 16'(mem_bus.MemReq), 16'h1);
        chk("post_rst_memaddr", mem_bus.MemAddr, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_instr_fetch
